// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand store.
// Provides the largest legal keypad digit, the BCD nibble width, the
// entry-state enum used by operand_regfile and a constant clog2 helper
// usable in port-width expressions.
package calc_pkg;

  localparam int unsigned DIGIT_MAX = 9;
  localparam int unsigned BCD_W     = 4;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ENTRY,
    ST_FULL
  } entry_state_e;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/operand_regfile_digit_shift_buf.sv
// digit_shift_buf: DIGITS-nibble BCD display shift register.
// Ports:
//   CLK, RST  clock, async active-high reset (contents -> 0)
//   clr       clear all nibbles (wins over shifts)
//   shl       shift left one nibble, din enters the least-significant nibble
//   shr       shift right one nibble, zero enters the most-significant nibble
//   din       BCD digit shifted in on shl
//   dout      register contents, [3:0] = least-significant digit
module digit_shift_buf
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      clr,
  input  logic                      shl,
  input  logic                      shr,
  input  logic [BCD_W-1:0]          din,
  output logic [BCD_W*DIGITS-1:0]   dout
);

  // Widened views avoid zero-width slices when DIGITS == 1.
  logic [BCD_W*(DIGITS+1)-1:0] shl_ext;
  logic [BCD_W*(DIGITS+1)-1:0] shr_ext;

  assign shl_ext = {dout, din};
  assign shr_ext = {{BCD_W{1'b0}}, dout};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout <= '0;
    end else if (clr) begin
      dout <= '0;
    end else if (shl) begin
      dout <= shl_ext[BCD_W*DIGITS-1:0];
    end else if (shr) begin
      dout <= shr_ext[BCD_W*(DIGITS+1)-1:BCD_W];
    end
  end

endmodule

// File: rtl/operand_regfile.sv
// operand_regfile: calculator operand store.
// Accumulates keypad digits into a decimal entry, commits it into one of
// NUM_REGS registers and provides two registered read ports plus BCD
// display digits of the entry in progress.
// Ports:
//   CLK, RST     clock, async active-high reset
//   digit_vld    strobe: digit valid;  digit: keypad digit (legal 0..9)
//   commit       write entry to RF[wr_sel] and clear the entry
//   clear        abandon entry;  bksp: delete last digit (optional feature)
//   rd_sel_a/b   read selects; dout_a/b: registered RF reads (0 if out of range)
//   dis_digits   BCD of entry, [3:0] least significant
//   entry_cnt    digits entered;  full: entry_cnt == DIGITS
//   bad_digit    one-cycle pulse for an accepted strobe with digit > 9
//   ovf          sticky: legal digit dropped while full
// Configuration: define OPERAND_RF_BKSP_EN to enable backspace (acc/10).
// Same-cycle priority: clear > commit > bksp > digit_vld.
module operand_regfile
  import calc_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          digit_vld,
  input  logic [BCD_W-1:0]              digit,
  input  logic                          commit,
  input  logic [clog2(NUM_REGS)-1:0]    wr_sel,
  input  logic                          clear,
  input  logic                          bksp,
  input  logic [clog2(NUM_REGS)-1:0]    rd_sel_a,
  input  logic [clog2(NUM_REGS)-1:0]    rd_sel_b,
  output logic [DATA_W-1:0]             dout_a,
  output logic [DATA_W-1:0]             dout_b,
  output logic [BCD_W*DIGITS-1:0]       dis_digits,
  output logic [clog2(DIGITS+1)-1:0]    entry_cnt,
  output logic                          full,
  output logic                          bad_digit,
  output logic                          ovf
);

  localparam int unsigned SEL_W = clog2(NUM_REGS);
  localparam int unsigned CNT_W = clog2(DIGITS+1);
  localparam logic [SEL_W:0] NUM_REGS_V = (SEL_W+1)'(NUM_REGS);

  entry_state_e       state, state_nxt;
  logic [DATA_W-1:0]  acc;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  rf [NUM_REGS];

  logic bksp_req;
  logic digit_legal;
  logic take_clear, take_commit, take_bksp;
  logic digit_acc, digit_ovf, digit_bad;
  logic wr_ok, rd_ok_a, rd_ok_b;

  logic [DATA_W+3:0]  acc_mul;
  logic [DATA_W-1:0]  acc_div;
  logic [3:0]         unused_acc_hi;

`ifdef OPERAND_RF_BKSP_EN
  assign bksp_req = bksp;
  assign acc_div  = acc / DATA_W'(10);
`else
  logic unused_bksp;
  assign unused_bksp = bksp;
  assign bksp_req    = 1'b0;
  assign acc_div     = acc;
`endif

  // Parameter rule (10**DIGITS-1 < 2**DATA_W) keeps the top nibble zero.
  assign acc_mul       = ({4'b0000, acc} * (DATA_W+4)'(10)) + (DATA_W+4)'(digit);
  assign unused_acc_hi = acc_mul[DATA_W+3:DATA_W];

  assign digit_legal = (digit <= BCD_W'(DIGIT_MAX));
  assign wr_ok       = ({1'b0, wr_sel}   < NUM_REGS_V);
  assign rd_ok_a     = ({1'b0, rd_sel_a} < NUM_REGS_V);
  assign rd_ok_b     = ({1'b0, rd_sel_b} < NUM_REGS_V);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    take_clear  = 1'b0;
    take_commit = 1'b0;
    take_bksp   = 1'b0;
    digit_acc   = 1'b0;
    digit_ovf   = 1'b0;
    digit_bad   = 1'b0;
    if (clear) begin
      take_clear = 1'b1;
      state_nxt  = ST_EMPTY;
    end else if (commit) begin
      take_commit = 1'b1;
      state_nxt   = ST_EMPTY;
    end else if (bksp_req) begin
      // A backspace on an empty entry is ignored but still pre-empts a digit.
      if (state != ST_EMPTY) begin
        take_bksp = 1'b1;
        state_nxt = (cnt == CNT_W'(1)) ? ST_EMPTY : ST_ENTRY;
      end
    end else if (digit_vld) begin
      if (!digit_legal) begin
        digit_bad = 1'b1;
      end else if (state == ST_FULL) begin
        digit_ovf = 1'b1;
      end else begin
        digit_acc = 1'b1;
        state_nxt = (cnt == CNT_W'(DIGITS-1)) ? ST_FULL : ST_ENTRY;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      bad_digit <= digit_bad;
      if (take_clear || take_commit) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (take_bksp) begin
        acc <= acc_div;
        cnt <= cnt - CNT_W'(1);
      end else if (digit_acc) begin
        acc <= acc_mul[DATA_W-1:0];
        cnt <= cnt + CNT_W'(1);
      end else if (digit_ovf) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf <= '{default: '0};
    end else if (take_commit && wr_ok) begin
      rf[wr_sel] <= acc;
    end
  end

  // Reads sample the array before this edge's write: no write-through.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      dout_a <= rd_ok_a ? rf[rd_sel_a] : '0;
      dout_b <= rd_ok_b ? rf[rd_sel_b] : '0;
    end
  end

  digit_shift_buf #(
    .DIGITS (DIGITS)
  ) u_shift_buf (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (take_clear | take_commit),
    .shl  (digit_acc),
    .shr  (take_bksp),
    .din  (digit),
    .dout (dis_digits)
  );

  assign entry_cnt = cnt;
  assign full      = (cnt == CNT_W'(DIGITS));

endmodule

// File: tb/tb_operand_regfile.sv
// Bench for operand_regfile: a 4-register and a 3-register instance share
// stimulus; a queue-of-digits model predicts every output each cycle, and
// directed sequences pin the model with literal expectations.
module tb_operand_regfile;

  localparam int NR  = 4;
  localparam int NR3 = 3;
  localparam int DG  = 4;
  localparam int DW  = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic digit_vld = 1'b0, commit = 1'b0, clear = 1'b0, bksp = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [1:0] wr_sel = 2'd0, rd_sel_a = 2'd0, rd_sel_b = 2'd0;

  logic [DW-1:0]   dout_a, dout_b, dout_a3, dout_b3;
  logic [4*DG-1:0] dis, dis3;
  logic [2:0]      cnt, cnt3;
  logic            full, full3, bad, bad3, ovf, ovf3;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  operand_regfile #(.NUM_REGS(NR), .DIGITS(DG), .DATA_W(DW)) u_dut (
    .CLK(CLK), .RST(RST), .digit_vld(digit_vld), .digit(digit),
    .commit(commit), .wr_sel(wr_sel), .clear(clear), .bksp(bksp),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .dout_a(dout_a), .dout_b(dout_b),
    .dis_digits(dis), .entry_cnt(cnt), .full(full), .bad_digit(bad), .ovf(ovf)
  );

  operand_regfile #(.NUM_REGS(NR3), .DIGITS(DG), .DATA_W(DW)) u_dut3 (
    .CLK(CLK), .RST(RST), .digit_vld(digit_vld), .digit(digit),
    .commit(commit), .wr_sel(wr_sel), .clear(clear), .bksp(bksp),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .dout_a(dout_a3), .dout_b(dout_b3),
    .dis_digits(dis3), .entry_cnt(cnt3), .full(full3), .bad_digit(bad3), .ovf(ovf3)
  );

  // ---------------- behavioural model ----------------
  int q[$];                         // entered digits, q[0] most significant
  int m_rf4[NR]  = '{default: 0};
  int m_rf3[NR3] = '{default: 0};
  int e_da = 0, e_db = 0, e_da3 = 0, e_db3 = 0;
  bit m_bad = 1'b0, m_ovf = 1'b0;

  function automatic int entry_value();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  function automatic logic [4*DG-1:0] entry_bcd();
    logic [4*DG-1:0] d = '0;
    for (int i = 0; i < q.size(); i++) d[4*i +: 4] = 4'(q[q.size()-1-i]);
    return d;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      m_rf4 = '{default: 0};
      m_rf3 = '{default: 0};
      e_da = 0; e_db = 0; e_da3 = 0; e_db3 = 0;
      m_bad = 1'b0; m_ovf = 1'b0;
    end else begin
      e_da  = m_rf4[rd_sel_a];
      e_db  = m_rf4[rd_sel_b];
      e_da3 = (int'(rd_sel_a) < NR3) ? m_rf3[rd_sel_a] : 0;
      e_db3 = (int'(rd_sel_b) < NR3) ? m_rf3[rd_sel_b] : 0;
      m_bad = 1'b0;
      if (clear) begin
        q.delete();
        m_ovf = 1'b0;
      end else if (commit) begin
        m_rf4[wr_sel] = entry_value();
        if (int'(wr_sel) < NR3) m_rf3[wr_sel] = entry_value();
        q.delete();
        m_ovf = 1'b0;
      end
`ifdef OPERAND_RF_BKSP_EN
      else if (bksp) begin
        if (q.size() > 0) void'(q.pop_back());
      end
`endif
      else if (digit_vld) begin
        if (digit > 4'd9)        m_bad = 1'b1;
        else if (q.size() == DG) m_ovf = 1'b1;
        else                     q.push_back(int'(digit));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("dout_a",  32'(dout_a),  32'(e_da));
      chk("dout_b",  32'(dout_b),  32'(e_db));
      chk("dis",     32'(dis),     32'(entry_bcd()));
      chk("cnt",     32'(cnt),     32'(q.size()));
      chk("full",    32'(full),    32'(q.size() == DG));
      chk("bad",     32'(bad),     32'(m_bad));
      chk("ovf",     32'(ovf),     32'(m_ovf));
      chk("dout_a3", 32'(dout_a3), 32'(e_da3));
      chk("dout_b3", 32'(dout_b3), 32'(e_db3));
      chk("dis3",    32'(dis3),    32'(entry_bcd()));
      chk("cnt3",    32'(cnt3),    32'(q.size()));
      chk("full3",   32'(full3),   32'(q.size() == DG));
      chk("bad3",    32'(bad3),    32'(m_bad));
      chk("ovf3",    32'(ovf3),    32'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put_digit(input logic [3:0] d);
    digit_vld = 1'b1;
    digit     = d;
    tick();
    digit_vld = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_dout_a", 32'(dout_a), 0);
    chk("rst_dis",    32'(dis),    0);
    chk("rst_cnt",    32'(cnt),    0);
    chk("rst_flags",  32'({full, bad, ovf}), 0);
    RST = 1'b0;
    cmp_en = 1'b1;
    tick();

    // 1234 into R2, read through port A
    put_digit(4'd1); put_digit(4'd2); put_digit(4'd3); put_digit(4'd4);
    chk("dis_1234", 32'(dis), 32'h1234);
    commit = 1'b1; wr_sel = 2'd2; rd_sel_a = 2'd2;
    tick();
    commit = 1'b0;
    chk("commit_dis", 32'(dis), 0);
    chk("commit_cnt", 32'(cnt), 0);
    chk("no_wr_through", 32'(dout_a), 0);
    tick();
    chk("dout_a_1234", 32'(dout_a), 1234);

    // fill, overflow, commit clears ovf
    for (int i = 0; i < 4; i++) put_digit(4'd9);
    chk("full_9999", 32'(full), 1);
    put_digit(4'd5);
    chk("ovf_set", 32'(ovf), 1);
    chk("dis_9999", 32'(dis), 32'h9999);
    chk("cnt_full", 32'(cnt), 4);
    commit = 1'b1; wr_sel = 2'd1; rd_sel_b = 2'd1;
    tick();
    commit = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);
    tick();
    chk("dout_b_9999", 32'(dout_b), 9999);

    // illegal digit, then digit lost to commit
    digit_vld = 1'b1; digit = 4'hC;
    tick();
    digit_vld = 1'b0;
    chk("bad_pulse", 32'(bad), 1);
    chk("bad_cnt", 32'(cnt), 0);
    tick();
    chk("bad_gone", 32'(bad), 0);
    put_digit(4'd7);
    digit_vld = 1'b1; digit = 4'd3; commit = 1'b1; wr_sel = 2'd0; rd_sel_a = 2'd0;
    tick();
    digit_vld = 1'b0; commit = 1'b0;
    chk("digit_lost_cnt", 32'(cnt), 0);
    tick();
    chk("dout_a_7", 32'(dout_a), 7);

    // R3 exists only in the 4-register build
    put_digit(4'd5); put_digit(4'd5);
    commit = 1'b1; wr_sel = 2'd3; rd_sel_a = 2'd3; rd_sel_b = 2'd3;
    tick();
    commit = 1'b0;
    tick();
    chk("dout_a_55", 32'(dout_a), 55);
    chk("dout_b_55", 32'(dout_b), 55);
    chk("nr3_drop_a", 32'(dout_a3), 0);
    chk("nr3_drop_b", 32'(dout_b3), 0);

`ifdef OPERAND_RF_BKSP_EN
    put_digit(4'd5); put_digit(4'd6); put_digit(4'd7);
    bksp = 1'b1;
    tick();
    bksp = 1'b0;
    chk("bksp_dis", 32'(dis), 32'h0056);
    chk("bksp_cnt", 32'(cnt), 2);
    commit = 1'b1; wr_sel = 2'd0; rd_sel_a = 2'd0;
    tick();
    commit = 1'b0;
    tick();
    chk("bksp_acc", 32'(dout_a), 56);
    put_digit(4'd8);
    bksp = 1'b1; clear = 1'b1;
    tick();
    bksp = 1'b0; clear = 1'b0;
    chk("bksp_clear_cnt", 32'(cnt), 0);
`endif

    // randomized traffic
    repeat (3000) begin
      digit_vld = ($urandom_range(0, 1) == 1);
      digit     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
      commit    = ($urandom_range(0, 11) == 0);
      clear     = ($urandom_range(0, 24) == 0);
      bksp      = ($urandom_range(0, 7) == 0);
      wr_sel    = 2'($urandom_range(0, 3));
      rd_sel_a  = 2'($urandom_range(0, 3));
      rd_sel_b  = 2'($urandom_range(0, 3));
      tick();
      if ($urandom_range(0, 599) == 0) begin
        RST = 1'b1;
        #1;
        RST = 1'b0;
      end
    end
    digit_vld = 1'b0; commit = 1'b0; clear = 1'b0; bksp = 1'b0;

    // fill all registers, then reset mid-entry
    for (int r = 0; r < NR; r++) begin
      put_digit(4'(r + 1));
      commit = 1'b1; wr_sel = 2'(r);
      tick();
      commit = 1'b0;
    end
    rd_sel_a = 2'd2;
    tick();
    chk("pre_rst_r2", 32'(dout_a), 3);
    put_digit(4'd4); put_digit(4'd2);
    RST = 1'b1;
    #1;
    chk("mid_rst_dout", 32'({dout_a, dout_b}), 0);
    chk("mid_rst_dis", 32'(dis), 0);
    chk("mid_rst_cnt", 32'(cnt), 0);
    chk("mid_rst_flags", 32'({full, bad, ovf}), 0);
    RST = 1'b0;
    put_digit(4'd3);
    chk("post_rst_cnt", 32'(cnt), 1);
    for (int r = 0; r < NR; r++) begin
      rd_sel_a = 2'(r);
      tick();
      chk("rf_cleared", 32'(dout_a), 0);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
